// File: rtl/matrix_stream_loader_pkg.sv
// matrix_stream_loader_pkg: shared defaults and index-width helper for the matrix streaming blocks
package matrix_stream_loader_pkg;

    localparam int DEF_BITLENGTH = 8;
    localparam int DEF_H = 3;
    localparam int DEF_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: row-major (row, col) position within an H x W matrix
module matrix_index_counter
    import matrix_stream_loader_pkg::*;
#(
    parameter int H = DEF_H,
    parameter int W = DEF_W,
    localparam int RW = idx_w(H),
    localparam int CW = idx_w(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          at_end
);

    logic row_end;
    logic col_end;

    assign row_end = (row == RW'(H - 1));
    assign col_end = (col == CW'(W - 1));
    assign at_end  = row_end && col_end;

    // Column runs fastest and wraps into the next row; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end)
                row <= row_end ? '0 : row + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: assembles a row-major element stream into a packed H x W matrix
module matrix_stream_loader
    import matrix_stream_loader_pkg::*;
#(
    parameter int bitlength = DEF_BITLENGTH,
    parameter int H = DEF_H,
    parameter int W = DEF_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [bitlength-1:0]     in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [H*W*bitlength-1:0] MO,
    output logic                     mo_valid,
    input  logic                     mo_ready,
    output logic                     frame_err
);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    localparam int RW = idx_w(H);
    localparam int CW = idx_w(W);

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          at_end;
    logic          accept;
    logic          clr;
    logic [31:0]   base;

    // in_ready is held low during reset even though the state already reads FILL
    assign in_ready = rst_n && (state == FILL);
    assign accept   = in_valid && in_ready;
    assign clr      = (accept && (at_end || in_last)) || (mo_valid && mo_ready);
    assign base     = (32'(row) * 32'(W) + 32'(col)) * 32'(bitlength);

    matrix_index_counter #(.H(H), .W(W)) u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .clr   (clr),
        .row   (row),
        .col   (col),
        .at_end(at_end)
    );

    // Fill/hold FSM: store each accepted element in place, flag frames whose last marker is misplaced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            MO        <= '0;
            mo_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept && (at_end != in_last);
            if (accept)
                MO[base +: bitlength] <= in_data;
            if (accept && at_end && in_last) begin
                state    <= HOLD;
                mo_valid <= 1'b1;
            end else if (state == HOLD && mo_ready) begin
                state    <= FILL;
                mo_valid <= 1'b0;
            end
        end
    end

endmodule
